obstacle_placer: RTL and testbench
==================================

# obstacle_placer

Consumer of the obstacle coordinate generator. On a placement request, it pulses the generator's advance flag and samples the new coordinate. It rejects candidates that collide with existing obstacles, the snake body or the head's safety zone, and retries up to a bound. Accepted coordinates go into a small obstacle table, which the renderer and the collision logic query each cycle.

## Interface
- MAX_OBST, 4: obstacle table capacity (1..7)
- MAX_TRIES, 8: candidate attempts per request before failing (1..15)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous and active-high
- place_req  in  1  one-cycle request to place one obstacle
- clear  in  1  one-cycle request to empty the table and abort any placement
- rand_x, rand_y  in  4 each  coordinate from the generator
- obstacle_flag  out  1  one-cycle advance pulse to the generator
- head_x, head_y  in  4 each  current snake head cell
- occ_x, occ_y  out  4 each  candidate cell presented to the snake-body lookup
- occ_hit  in  1  combinational: snake body occupies (occ_x, occ_y)
- q_x, q_y  in  4 each  query cell (renderer/collision)
- q_hit  out  1  combinational: (q_x, q_y) holds a stored obstacle
- busy  out  1  placement in progress
- done  out  1  one-cycle pulse: obstacle committed
- fail  out  1  one-cycle pulse: request abandoned
- obst_count  out  3  valid entries in the table

## Operation
- The grid is x in 1..14 and y in 1..10. Coordinate 0 and values above these bounds are off-grid.
- The FSM states are IDLE, REQ, CHECK and RESP.
- IDLE:
  - place_req with obst_count < MAX_OBST goes to REQ, clears the try counter and sets busy.
  - place_req with the table full goes to RESP with fail set; obstacle_flag is never pulsed.
- REQ: obstacle_flag=1 for exactly this cycle, then go to CHECK.
- CHECK:
  - occ_x/occ_y = rand_x/rand_y.
  - The candidate is rejected if any of these hold:
    - it is off-grid;
    - occ_hit=1;
    - |x−head_x|≤1 and |y−head_y|≤1, computed with 5-bit signed differences;
    - it equals any valid table entry.
  - Accept: write the candidate into the lowest free slot, increment obst_count, go to RESP with done set.
  - Reject: increment the try counter. If it reaches MAX_TRIES, go to RESP with fail set; otherwise go to REQ.
- RESP: pulse done or fail for one cycle, deassert busy, return to IDLE.
- place_req outside IDLE is ignored, with no queuing.
- clear in any state:
  - on the next edge, invalidate all entries, set obst_count=0 and go to IDLE;
  - no done or fail is produced;
  - clear wins over a simultaneous place_req or accept.
- q_hit is a pure combinational OR over valid entries. An entry written at an edge is visible to q_hit from the following cycle.
- occ_x/occ_y are 0 outside CHECK.

## Timing
- Reset values:
  - state=IDLE; busy, done, fail and obstacle_flag all 0;
  - obst_count=0, all entries invalid, try counter 0;
  - occ_x/occ_y=0; q_hit=0.
- The generator updates on the edge that ends REQ, so CHECK (one cycle later) sees the new rand_x/rand_y.
- Success on the first try:
  - place_req at cycle 0;
  - obstacle_flag at cycle 1 (REQ);
  - CHECK at cycle 2;
  - done and updated obst_count at cycle 3.
- Each rejected try adds 2 cycles, so worst-case fail latency is 2·MAX_TRIES+1 cycles after place_req.
- Full-table fail pulse arrives at cycle 1.
- busy is high from cycle 1 through the last REQ/CHECK cycle, and is low in RESP.
- rst mid-placement aborts with no pulse. The generator sees no partial flag, because obstacle_flag is a registered Moore output.

## Structure
- Package obstacle_pkg holds:
  - GRID_X_MAX=14 and GRID_Y_MAX=10;
  - the 4-bit coordinate typedef;
  - a packed struct {valid, x, y} for table entries;
  - the FSM state enum.
- Sub-module obstacle_table holds the MAX_OBST entries, the write-lowest-free logic, clear, obst_count, the q_hit lookup and the candidate-duplicate compare port.
- The FSM, try counter and head-zone check live in obstacle_placer.

## Test plan
- Reset, then place_req with rand=(8,3), head=(2,2), occ_hit=0:
  - obstacle_flag at cycle 1, done at cycle 3, obst_count=1;
  - q_hit=1 for query (8,3) and 0 for (8,4).
- Head-zone rejection: head=(8,3), first candidate (9,4), second (5,6):
  - two obstacle_flag pulses, done at cycle 5, table holds (5,6).
- occ_hit is held at 1, MAX_TRIES=8:
  - exactly 8 obstacle_flag pulses;
  - fail pulse at cycle 17;
  - obst_count unchanged and busy low afterwards.
- Fill 4 slots, then place_req:
  - fail at cycle 1, no obstacle_flag.
  - A candidate equal to a stored entry is rejected as a duplicate.
- clear asserted during CHECK of an accepting candidate:
  - next cycle obst_count=0 and state IDLE, no done;
  - q_hit=0 for all cells.
- rst asserted mid-REQ:
  - immediate return to the reset values;
  - a subsequent place_req completes normally.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared types, grid bounds and helpers for obstacle placement.
// The playable grid is x in 1..14, y in 1..10; zero and larger values are off-grid.
package obstacle_pkg;

  typedef logic [3:0] coord_t;

  localparam coord_t GRID_X_MAX = 4'd14;
  localparam coord_t GRID_Y_MAX = 4'd10;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, CHECK, RESP} state_t;

  function automatic logic on_grid(input coord_t x, input coord_t y);
    return (x != 4'd0) && (x <= GRID_X_MAX) && (y != 4'd0) && (y <= GRID_Y_MAX);
  endfunction

endpackage

// File: rtl/obstacle_table.sv
// Small obstacle table: lowest-free-slot insertion, bulk clear, occupancy count,
// a query lookup for the renderer and a duplicate check for the current candidate.
module obstacle_table
  import obstacle_pkg::*;
#(
  parameter int MAX_OBST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [3:0] cand_x,
  input  logic [3:0] cand_y,
  input  logic [3:0] q_x,
  input  logic [3:0] q_y,
  output logic       q_hit,
  output logic       cand_dup,
  output logic       full,
  output logic [2:0] obst_count
);

  localparam logic [2:0] CAPACITY = 3'(MAX_OBST);

  entry_t              entries [MAX_OBST];
  logic [MAX_OBST-1:0] free_onehot;
  logic                free_found;

  always_comb begin
    free_onehot = '0;
    free_found  = 1'b0;
    for (int i = 0; i < MAX_OBST; i++) begin
      if (!entries[i].valid && !free_found) begin
        free_onehot[i] = 1'b1;
        free_found     = 1'b1;
      end
    end
  end

  always_comb begin
    q_hit    = 1'b0;
    cand_dup = 1'b0;
    for (int i = 0; i < MAX_OBST; i++) begin
      if (entries[i].valid && entries[i].x == q_x && entries[i].y == q_y)
        q_hit = 1'b1;
      if (entries[i].valid && entries[i].x == cand_x && entries[i].y == cand_y)
        cand_dup = 1'b1;
    end
  end

  // Clear takes priority over a same-cycle insertion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OBST; i++) entries[i] <= '0;
      obst_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < MAX_OBST; i++) entries[i] <= '0;
      obst_count <= '0;
    end else if (wr_en && free_found) begin
      for (int i = 0; i < MAX_OBST; i++) begin
        if (free_onehot[i]) entries[i] <= '{valid: 1'b1, x: wr_x, y: wr_y};
      end
      obst_count <= obst_count + 3'd1;
    end
  end

  assign full = (obst_count >= CAPACITY);

endmodule

// File: rtl/obstacle_placer.sv
// Requests candidate cells from the coordinate generator, rejects unsafe or
// duplicate ones with bounded retries, and commits accepted cells to the table.
module obstacle_placer
  import obstacle_pkg::*;
#(
  parameter int MAX_OBST  = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       place_req,
  input  logic       clear,
  input  logic [3:0] rand_x,
  input  logic [3:0] rand_y,
  output logic       obstacle_flag,
  input  logic [3:0] head_x,
  input  logic [3:0] head_y,
  output logic [3:0] occ_x,
  output logic [3:0] occ_y,
  input  logic       occ_hit,
  input  logic [3:0] q_x,
  input  logic [3:0] q_y,
  output logic       q_hit,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] obst_count
);

  localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

  state_t            state;
  logic [3:0]        tries;
  logic [3:0]        tries_next;
  logic signed [4:0] dx;
  logic signed [4:0] dy;
  logic              in_head_zone;
  logic              cand_dup;
  logic              table_full;
  logic              reject;
  logic              wr_en;

  // The generator output is only meaningful while checking a fresh candidate.
  assign occ_x = (state == CHECK) ? rand_x : 4'd0;
  assign occ_y = (state == CHECK) ? rand_y : 4'd0;

  assign dx = $signed({1'b0, rand_x}) - $signed({1'b0, head_x});
  assign dy = $signed({1'b0, rand_y}) - $signed({1'b0, head_y});
  assign in_head_zone = (dx >= -5'sd1) && (dx <= 5'sd1) && (dy >= -5'sd1) && (dy <= 5'sd1);

  assign reject     = !on_grid(rand_x, rand_y) || occ_hit || in_head_zone || cand_dup;
  assign wr_en      = (state == CHECK) && !reject;
  assign tries_next = tries + 4'd1;

  obstacle_table #(.MAX_OBST(MAX_OBST)) u_table (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_x       (rand_x),
    .wr_y       (rand_y),
    .cand_x     (rand_x),
    .cand_y     (rand_y),
    .q_x        (q_x),
    .q_y        (q_y),
    .q_hit      (q_hit),
    .cand_dup   (cand_dup),
    .full       (table_full),
    .obst_count (obst_count)
  );

  // Pulses default low each cycle so done/fail/obstacle_flag last exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tries         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      obstacle_flag <= 1'b0;
    end else begin
      done          <= 1'b0;
      fail          <= 1'b0;
      obstacle_flag <= 1'b0;
      if (clear) begin
        state <= IDLE;
        tries <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (place_req) begin
              if (table_full) begin
                state <= RESP;
                fail  <= 1'b1;
              end else begin
                state         <= REQ;
                tries         <= '0;
                busy          <= 1'b1;
                obstacle_flag <= 1'b1;
              end
            end
          end
          REQ: state <= CHECK;
          CHECK: begin
            if (!reject) begin
              state <= RESP;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (tries_next == TRY_LIMIT) begin
              state <= RESP;
              fail  <= 1'b1;
              busy  <= 1'b0;
              tries <= tries_next;
            end else begin
              state         <= REQ;
              obstacle_flag <= 1'b1;
              tries         <= tries_next;
            end
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_placer.sv
// Bench for obstacle_placer: a cycle-indexed plan/table model predicts every output,
// with directed scenarios pinned by literal timing expectations and a randomized phase.
module tb_obstacle_placer;

  localparam int MAX_OBST  = 4;
  localparam int MAX_TRIES = 8;
  localparam int NEVER     = 32'h7fff_ffff;
  localparam int NREQ      = 40;

  logic       clk, rst, place_req, clear;
  logic [3:0] rand_x, rand_y, head_x, head_y, occ_x, occ_y, q_x, q_y;
  logic       obstacle_flag, occ_hit, q_hit, busy, done, fail;
  logic [2:0] obst_count;

  obstacle_placer #(.MAX_OBST(MAX_OBST), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst), .place_req(place_req), .clear(clear),
    .rand_x(rand_x), .rand_y(rand_y), .obstacle_flag(obstacle_flag),
    .head_x(head_x), .head_y(head_y), .occ_x(occ_x), .occ_y(occ_y),
    .occ_hit(occ_hit), .q_x(q_x), .q_y(q_y), .q_hit(q_hit),
    .busy(busy), .done(done), .fail(fail), .obst_count(obst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  bit test_done = 0;
  bit check_on = 0;

  // Environment: snake body map answering the occupancy lookup.
  logic [255:0] body_map;
  logic         force_occ;
  assign occ_hit = force_occ | body_map[{occ_x, occ_y}];

  // Model: obstacle table as entries alive over [from, until) cycles, plus one placement plan.
  int ent_x[512], ent_y[512], ent_from[512], ent_until[512];
  int n_ent = 0;
  int cand_x[MAX_TRIES], cand_y[MAX_TRIES];
  int gen_idx = 0;
  bit plan_valid = 0, plan_ok = 0;
  int req_c = 0, n_tries = 0, resp_c = 0, cut_c = NEVER;

  bit q_force = 0;
  int q_fx = 0, q_fy = 0, px = 0, py = 0;
  bit gen_flag;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int live_count(input int k);
    int n = 0;
    for (int i = 0; i < n_ent; i++) if (ent_from[i] <= k && k < ent_until[i]) n++;
    return n;
  endfunction

  function automatic bit stored_at(input int x, input int y, input int k);
    for (int i = 0; i < n_ent; i++)
      if (ent_from[i] <= k && k < ent_until[i] && ent_x[i] == x && ent_y[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pick_live(input int k);
    int n = live_count(k);
    int sel;
    if (n == 0) return 1'b0;
    sel = int'($urandom_range(0, n - 1));
    for (int i = 0; i < n_ent; i++) begin
      if (ent_from[i] <= k && k < ent_until[i]) begin
        if (sel == 0) begin
          px = ent_x[i];
          py = ent_y[i];
          return 1'b1;
        end
        sel--;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit model_accept(input int x, input int y, input int k);
    int dxa, dya;
    if (x < 1 || x > 14 || y < 1 || y > 10) return 1'b0;
    if (force_occ || body_map[x * 16 + y]) return 1'b0;
    dxa = x - int'(head_x);
    dya = y - int'(head_y);
    if (dxa < 0) dxa = -dxa;
    if (dya < 0) dya = -dya;
    if (dxa <= 1 && dya <= 1) return 1'b0;
    if (stored_at(x, y, k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void truncate(input int cut);
    for (int i = 0; i < n_ent; i++) if (ent_until[i] > cut) ent_until[i] = cut;
    if (cut_c > cut) cut_c = cut;
  endfunction

  function automatic void make_plan(input int c);
    plan_valid = 1'b1;
    plan_ok    = 1'b0;
    req_c      = c;
    cut_c      = NEVER;
    gen_idx    = 0;
    if (live_count(c) >= MAX_OBST) begin
      n_tries = 0;
      resp_c  = c + 1;
    end else begin
      n_tries = MAX_TRIES;
      for (int j = 0; j < MAX_TRIES; j++) begin
        if (model_accept(cand_x[j], cand_y[j], c)) begin
          n_tries = j + 1;
          plan_ok = 1'b1;
          break;
        end
      end
      resp_c = c + 2 * n_tries + 1;
      if (plan_ok) begin
        ent_x[n_ent]     = cand_x[n_tries - 1];
        ent_y[n_ent]     = cand_y[n_tries - 1];
        ent_from[n_ent]  = resp_c;
        ent_until[n_ent] = NEVER;
        n_ent++;
      end
    end
  endfunction

  function automatic bit plan_active(input int c);
    return plan_valid && c <= resp_c && c < cut_c;
  endfunction

  // Drives one cycle of inputs shortly after the rising edge and updates the model.
  task automatic applyStimulus(input bit req, input bit clr, input bit rs);
    @(posedge clk);
    #2;
    place_req = req;
    clear     = clr;
    rst       = rs;
    if (q_force) begin
      q_x = 4'(q_fx);
      q_y = 4'(q_fy);
    end else if ($urandom_range(0, 1) == 1 && pick_live(cyc)) begin
      q_x = 4'(px);
      q_y = 4'(py);
    end else begin
      q_x = 4'($urandom_range(0, 15));
      q_y = 4'($urandom_range(0, 15));
    end
    if (rs) truncate(cyc);
    else if (clr) truncate(cyc + 1);
    else if (req && !plan_active(cyc)) make_plan(cyc);
  endtask

  // Generator stand-in: presents the next candidate on the edge that ends a flag cycle.
  initial begin
    rand_x = 4'd0;
    rand_y = 4'd0;
    forever begin
      @(negedge clk);
      gen_flag = obstacle_flag;
      @(posedge clk);
      #1;
      if (gen_flag) begin
        if (gen_idx < MAX_TRIES) begin
          rand_x = 4'(cand_x[gen_idx]);
          rand_y = 4'(cand_y[gen_idx]);
        end
        gen_idx++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  int k, off, e_ox, e_oy;
  bit alive;
  initial begin
    wait (check_on);
    while (!test_done) begin
      @(negedge clk);
      if (test_done) break;
      k     = cyc;
      alive = plan_valid && k > req_c && k <= resp_c && k < cut_c;
      off   = k - req_c;
      e_ox  = 0;
      e_oy  = 0;
      if (alive && off % 2 == 0 && off >= 2 && off <= 2 * n_tries) begin
        e_ox = cand_x[off / 2 - 1];
        e_oy = cand_y[off / 2 - 1];
      end
      checkOutput("obstacle_flag", int'(obstacle_flag),
                  int'(alive && off % 2 == 1 && off <= 2 * n_tries - 1));
      checkOutput("busy", int'(busy), int'(alive && k < resp_c));
      checkOutput("done", int'(done), int'(alive && k == resp_c && plan_ok));
      checkOutput("fail", int'(fail), int'(alive && k == resp_c && !plan_ok));
      checkOutput("obst_count", int'(obst_count), live_count(k));
      checkOutput("occ_x", int'(occ_x), e_ox);
      checkOutput("occ_y", int'(occ_y), e_oy);
      checkOutput("q_hit", int'(q_hit), int'(stored_at(int'(q_x), int'(q_y), k)));
    end
  end

  task automatic observe(input int n, output int nflag, output int first, output int done_at,
                         output int fail_at);
    nflag = 0; first = -1; done_at = -1; fail_at = -1;
    for (int i = 1; i <= n; i++) begin
      applyStimulus(0, 0, 0);
      @(negedge clk);
      if (obstacle_flag) begin
        nflag++;
        if (first < 0) first = i;
      end
      if (done) done_at = i;
      if (fail) fail_at = i;
    end
  endtask

  task automatic set_cands(input int x0, input int y0, input int x1, input int y1);
    for (int j = 0; j < MAX_TRIES; j++) begin
      cand_x[j] = int'($urandom_range(0, 15));
      cand_y[j] = int'($urandom_range(0, 11));
    end
    cand_x[0] = x0; cand_y[0] = y0;
    cand_x[1] = x1; cand_y[1] = y1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int nf, ff, da, fa, clr_at;
  bit extra;
  initial begin
    rst = 1'b1; place_req = 1'b0; clear = 1'b0;
    head_x = 4'd2; head_y = 4'd2; q_x = 4'd0; q_y = 4'd0;
    body_map = '0; force_occ = 1'b0;
    set_cands(0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("reset obstacle_flag", int'(obstacle_flag), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset fail", int'(fail), 0);
    checkOutput("reset obst_count", int'(obst_count), 0);
    checkOutput("reset occ_x", int'(occ_x), 0);
    checkOutput("reset occ_y", int'(occ_y), 0);
    checkOutput("reset q_hit", int'(q_hit), 0);
    check_on = 1'b1;

    // First-try success.
    set_cands(8, 3, 1, 1);
    applyStimulus(1, 0, 0);
    observe(5, nf, ff, da, fa);
    checkOutput("t1 flag count", nf, 1);
    checkOutput("t1 flag cycle", ff, 1);
    checkOutput("t1 done cycle", da, 3);
    checkOutput("t1 obst_count", int'(obst_count), 1);
    q_force = 1'b1; q_fx = 8; q_fy = 3;
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("t1 q_hit(8,3)", int'(q_hit), 1);
    q_fy = 4;
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("t1 q_hit(8,4)", int'(q_hit), 0);
    q_force = 1'b0;

    // Head-zone rejection then success.
    head_x = 4'd8; head_y = 4'd3;
    set_cands(9, 4, 5, 6);
    applyStimulus(1, 0, 0);
    observe(7, nf, ff, da, fa);
    checkOutput("t2 flag count", nf, 2);
    checkOutput("t2 done cycle", da, 5);
    checkOutput("t2 obst_count", int'(obst_count), 2);
    q_force = 1'b1; q_fx = 5; q_fy = 6;
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("t2 q_hit(5,6)", int'(q_hit), 1);
    q_force = 1'b0;

    // Body always occupied: every try rejected.
    force_occ = 1'b1;
    set_cands(11, 8, 12, 8);
    applyStimulus(1, 0, 0);
    observe(19, nf, ff, da, fa);
    checkOutput("t3 flag count", nf, MAX_TRIES);
    checkOutput("t3 fail cycle", fa, 2 * MAX_TRIES + 1);
    checkOutput("t3 done cycle", da, -1);
    checkOutput("t3 obst_count", int'(obst_count), 2);
    checkOutput("t3 busy after", int'(busy), 0);
    force_occ = 1'b0;

    // Duplicate rejection, then fill the table.
    head_x = 4'd14; head_y = 4'd1;
    set_cands(8, 3, 12, 9);
    applyStimulus(1, 0, 0);
    observe(7, nf, ff, da, fa);
    checkOutput("dup flag count", nf, 2);
    checkOutput("dup done cycle", da, 5);
    set_cands(3, 8, 4, 8);
    applyStimulus(1, 0, 0);
    observe(5, nf, ff, da, fa);
    checkOutput("fill done cycle", da, 3);
    checkOutput("fill obst_count", int'(obst_count), 4);
    set_cands(6, 6, 7, 7);
    applyStimulus(1, 0, 0);
    observe(3, nf, ff, da, fa);
    checkOutput("full fail cycle", fa, 1);
    checkOutput("full flag count", nf, 0);
    checkOutput("full obst_count", int'(obst_count), 4);

    // Clear during CHECK of an accepting candidate.
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    head_x = 4'd2; head_y = 4'd2;
    set_cands(10, 5, 1, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("clr done", int'(done), 0);
    checkOutput("clr busy", int'(busy), 0);
    checkOutput("clr obst_count", int'(obst_count), 0);
    q_force = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        q_fx = x; q_fy = y;
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("clr q_hit scan", int'(q_hit), 0);
      end
    end
    q_force = 1'b0;

    // Reset asserted during REQ.
    set_cands(8, 3, 1, 1);
    applyStimulus(1, 0, 0);
    observe(3, nf, ff, da, fa);
    set_cands(9, 9, 1, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    @(negedge clk);
    checkOutput("rst obstacle_flag", int'(obstacle_flag), 0);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst obst_count", int'(obst_count), 0);
    applyStimulus(0, 0, 0);
    set_cands(8, 3, 1, 1);
    applyStimulus(1, 0, 0);
    observe(4, nf, ff, da, fa);
    checkOutput("post-rst flag count", nf, 1);
    checkOutput("post-rst done cycle", da, 3);
    checkOutput("post-rst obst_count", int'(obst_count), 1);

    // Randomized requests with stray requests and occasional clears.
    for (int r = 0; r < NREQ; r++) begin
      if (live_count(cyc) >= MAX_OBST && $urandom_range(0, 1) == 1) begin
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
      end
      head_x = 4'($urandom_range(1, 14));
      head_y = 4'($urandom_range(1, 10));
      for (int i = 0; i < 256; i++) body_map[i] = ($urandom_range(0, 99) < 12);
      force_occ = ($urandom_range(0, 19) == 0);
      for (int j = 0; j < MAX_TRIES; j++) begin
        if ($urandom_range(0, 3) == 0 && pick_live(cyc + 1)) begin
          cand_x[j] = px; cand_y[j] = py;
        end else begin
          cand_x[j] = int'($urandom_range(0, 15));
          cand_y[j] = int'($urandom_range(0, 11));
        end
      end
      applyStimulus(1, 0, 0);
      clr_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2 * MAX_TRIES + 1)) : -1;
      for (int s = 1; s <= 2 * MAX_TRIES + 2; s++) begin
        extra = ($urandom_range(0, 5) == 0) && (req_c + s <= resp_c) && (req_c + s < cut_c);
        applyStimulus(extra, s == clr_at, 0);
        if (cyc > resp_c || cyc >= cut_c) break;
      end
      force_occ = 1'b0;
    end
    applyStimulus(0, 0, 0);

    test_done = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
